// File: rtl/tristate_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tristate_bus_arbiter
//
// Lets N channels share one WIDTH-bit tristate output bus. A round-robin
// arbiter hands out ownership, a burst limit bounds each tenure when other
// channels are waiting, and every change of owner is separated by a forced
// high-Z turnaround so two drivers never overlap on the bus net.
//
// Ports:
//   clk    in   1          rising-edge clock
//   rst    in   1          synchronous, active-high reset
//   req    in   N          per-channel bus request (level)
//   Q      in   N*WIDTH    channel data, channel i at [i*WIDTH +: WIDTH]
//   grant  out  N          one-hot ownership (registered)
//   E      out  1          bus enable (registered), high exactly when O is driven
//   O      out  WIDTH      owner's Q when E=1, otherwise high-Z
//   owner  out  $clog2(N)  index of current/last owner (registered)
//   busy   out  1          high while driving or in turnaround
// -----------------------------------------------------------------------------
module tristate_bus_arbiter #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned N          = 4,
    parameter int unsigned TURNAROUND = 1,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req,
    input  logic [N*WIDTH-1:0]     Q,
    output logic [N-1:0]           grant,
    output logic                   E,
    output logic [WIDTH-1:0]       O,
    output logic [$clog2(N)-1:0]   owner,
    output logic                   busy
);

    localparam int unsigned OW = $clog2(N);
    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    localparam int unsigned TW = $clog2(TURNAROUND + 1);

    localparam logic [BW-1:0] BurstMax = BW'(MAX_BURST);
    localparam logic [TW-1:0] TurnMax  = TW'(TURNAROUND);
    localparam logic [OW:0]   NumCh    = (OW + 1)'(N);

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StTurn
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic            en_q, en_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [TW-1:0]   turn_q, turn_d;

    // Round-robin pick: first set request strictly after the pointer, wrapping.
    logic [OW-1:0]   sel;
    logic            sel_valid;
    logic [OW:0]     cand;

    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        cand      = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            // One extra bit so ptr + i never overflows before the wrap.
            cand = {1'b0, ptr_q} + (OW + 1)'(i);
            if (cand >= NumCh) begin
                cand = cand - NumCh;
            end
            if (!sel_valid && req[cand[OW-1:0]]) begin
                sel_valid = 1'b1;
                sel       = cand[OW-1:0];
            end
        end
    end

    logic owner_req;
    logic competitor;

    assign owner_req  = req[owner_q];
    assign competitor = |(req & ~grant_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        en_d    = en_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        turn_d  = turn_q;

        unique case (state_q)
            StIdle: begin
                if (sel_valid) begin
                    state_d      = StDrive;
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    owner_d      = sel;
                    en_d         = 1'b1;
                    burst_d      = BW'(1);
                    ptr_d        = sel;
                end
            end
            StDrive: begin
                if (!owner_req || (burst_q == BurstMax && competitor)) begin
                    state_d = StTurn;
                    grant_d = '0;
                    en_d    = 1'b0;
                    turn_d  = TW'(1);
                end else if (burst_q != BurstMax) begin
                    // Saturates: a lone owner may hold the bus indefinitely.
                    burst_d = burst_q + BW'(1);
                end
            end
            StTurn: begin
                if (turn_q == TurnMax) begin
                    state_d = StIdle;
                end else begin
                    turn_d = turn_q + TW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
                en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            en_q    <= 1'b0;
            owner_q <= '0;
            // Pointer at the last channel so channel 0 wins first.
            ptr_q   <= OW'(N - 1);
            burst_q <= '0;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            en_q    <= en_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
            turn_q  <= turn_d;
        end
    end

    assign grant = grant_q;
    assign E     = en_q;
    assign owner = owner_q;
    assign busy  = (state_q != StIdle);

    // Data path is deliberately unregistered so O tracks the owner's Q in-cycle.
    assign O = en_q ? Q[WIDTH * int'(owner_q) +: WIDTH] : {WIDTH{1'bz}};

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
module tb_tristate_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] q;

    // Instance a: MAX_BURST=16; instance b: MAX_BURST=2 (round-robin scenario).
    logic [3:0]  grant_a, grant_b;
    logic        e_a, e_b;
    wire  [7:0]  o_a, o_b;
    logic [1:0]  owner_a, owner_b;
    logic        busy_a, busy_b;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    tristate_bus_arbiter #(
        .WIDTH      (8),
        .N          (4),
        .TURNAROUND (1),
        .MAX_BURST  (16)
    ) dut_a (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .Q     (q),
        .grant (grant_a),
        .E     (e_a),
        .O     (o_a),
        .owner (owner_a),
        .busy  (busy_a)
    );

    tristate_bus_arbiter #(
        .WIDTH      (8),
        .N          (4),
        .TURNAROUND (1),
        .MAX_BURST  (2)
    ) dut_b (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .Q     (q),
        .grant (grant_b),
        .E     (e_b),
        .O     (o_b),
        .owner (owner_b),
        .busy  (busy_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input bit use_b, input logic [3:0] eg,
                                input logic ee, input logic [1:0] eo, input logic eb);
        logic [3:0] g;
        logic       e;
        logic [1:0] o;
        logic       b;
        g = use_b ? grant_b : grant_a;
        e = use_b ? e_b : e_a;
        o = use_b ? owner_b : owner_a;
        b = use_b ? busy_b : busy_a;
        check({tag, ".grant"}, 32'(g), 32'(eg));
        check({tag, ".E"},     32'(e), 32'(ee));
        check({tag, ".owner"}, 32'(o), 32'(eo));
        check({tag, ".busy"},  32'(b), 32'(eb));
    endtask

    int   zero_run;
    bit   seen_grant;
    logic prev_e;

    initial begin
        rst = 1'b1;
        req = 4'b1111;
        q   = {8'h44, 8'h33, 8'h22, 8'h11};

        // Reset hold with all channels requesting.
        repeat (3) begin
            tick();
            expect_state("reset_hold_a", 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
            expect_state("reset_hold_b", 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
        end
        rst = 1'b0;
        tick();
        expect_state("first_grant_a", 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1);
        expect_state("first_grant_b", 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1);
        check("first_grant.O", 32'(o_a), 32'(8'h11));

        req = 4'b0000;
        tick();
        expect_state("release_turn", 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1);
        tick();
        expect_state("release_idle", 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);

        // Single requester on channel 2 for five cycles.
        q[23:16] = 8'hA5;
        req      = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            tick();
            expect_state("single_drive", 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1);
            check("single_drive.O", 32'(o_a), 32'(8'hA5));
        end
        // Channel 2 drops; others wait through TURNAROUND+1 idle cycles.
        req = 4'b1011;
        tick();
        expect_state("single_gap1", 1'b0, 4'b0000, 1'b0, 2'd2, 1'b1);
        tick();
        expect_state("single_gap2", 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0);
        tick();
        expect_state("after_gap", 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1);
        check("after_gap.O", 32'(o_a), 32'(8'h44));
        req = 4'b0000;
        tick();
        tick();

        // Round-robin with MAX_BURST=2: 2 cycles driving, 2 cycles off per owner.
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 4; c++) begin
                logic [7:0] exp_byte;
                logic [31:0] qv;
                tick();
                expect_state("round_robin", 1'b1, (c < 2) ? 4'(1 << (k % 4)) : 4'b0000,
                             (c < 2), 2'(k % 4), (c != 3));
                if (c < 2) begin
                    qv       = q;
                    exp_byte = qv[(k % 4) * 8 +: 8];
                    check("round_robin.O", 32'(o_b), 32'(exp_byte));
                end
            end
        end

        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
        tick();

        // Preemption: channel 0 holds, channel 3 joins from the 5th edge.
        req = 4'b0001;
        for (int c = 1; c <= 19; c++) begin
            tick();
            if (c <= 16) begin
                expect_state("preempt_hold", 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1);
            end else if (c == 17) begin
                expect_state("preempt_turn", 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1);
            end else if (c == 18) begin
                expect_state("preempt_idle", 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
            end else begin
                expect_state("preempt_next", 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1);
            end
            if (c == 4) req = 4'b1001;
        end

        // No competitor: channel 0 keeps the bus for 40 cycles.
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
        req = 4'b0001;
        for (int c = 0; c < 40; c++) begin
            tick();
            expect_state("lone_hold", 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1);
        end

        // Mid-drive reset restores the pointer (channel 0 just owned, ptr=0).
        req = 4'b0000;
        tick();
        tick();
        req = 4'b0001;
        repeat (3) begin
            tick();
            expect_state("mid_drive", 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1);
        end
        q[7:0] = 8'h5A;
        #1;
        check("comb_track.O", 32'(o_a), 32'(8'h5A));
        rst = 1'b1;
        tick();
        expect_state("mid_reset_a", 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        expect_state("mid_reset_b", 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
        rst = 1'b0;
        req = 4'b1001;
        tick();
        expect_state("ptr_restored_a", 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1);
        expect_state("ptr_restored_b", 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1);

        // Random contention on the short-burst instance.
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        zero_run   = 0;
        seen_grant = 1'b0;
        prev_e     = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(3) == 0) req = 4'($urandom);
            q = $urandom;
            tick();
            check("rand_onehot_a", 32'($onehot0(grant_a)), 32'(1));
            check("rand_onehot_b", 32'($onehot0(grant_b)), 32'(1));
            check("rand_E_a", 32'(e_a), 32'(grant_a != 4'b0000));
            check("rand_E_b", 32'(e_b), 32'(grant_b != 4'b0000));
            if (e_b && !prev_e && seen_grant) begin
                check("rand_gap", 32'(zero_run >= 2), 32'(1));
            end
            if (e_b) begin
                seen_grant = 1'b1;
                zero_run   = 0;
            end else begin
                zero_run++;
            end
            prev_e = e_b;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
